booth_mult_seq: RTL

Sequential radix-2 Booth signed multiplier for the processor's multiply/divide unit; it is the iterating stage that drives the 64-bit one-bit arithmetic-right-shift datapath. Each iteration conditionally adds or subtracts the multiplicand into the upper half of a product register, then shifts the whole register right arithmetically by one. It returns a full 2*WIDTH-bit signed product and flags results that do not fit in WIDTH bits, so the pipeline can raise a multiply exception.

---
 rtl/booth_mult_seq_if.sv | 24 ++
 rtl/booth_mult_seq.sv | 115 +++++++++++
 2 files changed

// File: rtl/booth_mult_seq_if.sv
// Handshake and operand/result bundle for the sequential Booth multiplier.
// The master side issues requests; the slave side (the multiplier) answers.
interface booth_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [2*WIDTH-1:0]   product;
  logic                 overflow;
  logic                 busy;
  logic                 ready;
  logic                 done;

  modport master (
    output start, multiplicand, multiplier,
    input  product, overflow, busy, ready, done
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output product, overflow, busy, ready, done
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth signed multiplier: one add/sub plus arithmetic
// right shift of {A, Q, q_1} per cycle, full 2*WIDTH-bit product and overflow flag.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  booth_mult_seq_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg, state_next;
  // A and M carry one extra bit so that subtracting the most-negative M keeps the sign.
  logic [WIDTH:0]   a_reg, a_next;
  logic [WIDTH:0]   m_reg, m_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             q1_reg, q1_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;

  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   a_sum;
  logic [WIDTH:0]   a_shift;
  logic [WIDTH-1:0] q_shift;
  logic [WIDTH:0]   prod_top;
  logic             ovf_step;

  assign accept    = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_step = (cnt_reg == CW'(WIDTH - 1));

  always_comb begin
    a_sum = a_reg;
    unique case ({q_reg[0], q1_reg})
      2'b01:   a_sum = a_reg + m_reg;
      2'b10:   a_sum = a_reg - m_reg;
      default: a_sum = a_reg;
    endcase
  end

  assign a_shift = {a_sum[WIDTH], a_sum[WIDTH:1]};
  assign q_shift = {a_sum[0], q_reg[WIDTH-1:1]};

  // Result fits in signed WIDTH only if product[2W-1:W-1] is all sign bits.
  assign prod_top = {a_shift[WIDTH-1:0], q_shift[WIDTH-1]};
  assign ovf_step = !((&prod_top) || (~|prod_top));

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    m_next     = m_reg;
    q_next     = q_reg;
    q1_next    = q1_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;

    unique case (state_reg)
      RUN: begin
        a_next  = a_shift;
        q_next  = q_shift;
        q1_next = q_reg[0];
        if (last_step) begin
          state_next = DONE;
          ovf_next   = ovf_step;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      IDLE, DONE: begin
        if (accept) begin
          state_next = RUN;
          a_next     = '0;
          q_next     = bus.multiplier;
          q1_next    = 1'b0;
          m_next     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
          cnt_next   = '0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      m_reg     <= '0;
      q_reg     <= '0;
      q1_reg    <= 1'b0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      m_reg     <= m_next;
      q_reg     <= q_next;
      q1_reg    <= q1_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
    end
  end

  // A and Q stay untouched outside RUN, so the product holds until the next start.
  assign bus.product  = {a_reg[WIDTH-1:0], q_reg};
  assign bus.overflow = ovf_reg;
  assign bus.busy     = (state_reg == RUN);
  assign bus.ready    = (state_reg == IDLE) || (state_reg == DONE);
  assign bus.done     = (state_reg == DONE);
endmodule
